// File: rtl/semaforo.sv
// Two-way traffic light controller. Four Moore phases, each held for a parameterised number of cycles.
// Optional request button (build macro SEMAFORO_BT_EN) cuts the A-green phase short.
module semaforo #(
    parameter logic [7:0] VERDE    = 8'd1,
    parameter logic [7:0] AMARELO  = 8'd3,
    parameter logic [7:0] VERMELHO = 8'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bt,
    output logic [2:0] A,
    output logic [2:0] B
);

    // One-hot phase register, so corrupted encodings can be detected and recovered.
    localparam logic [3:0] P0 = 4'b0001;
    localparam logic [3:0] P1 = 4'b0010;
    localparam logic [3:0] P2 = 4'b0100;
    localparam logic [3:0] P3 = 4'b1000;

    localparam logic [2:0] LT_GREEN  = 3'b001;
    localparam logic [2:0] LT_YELLOW = 3'b010;
    localparam logic [2:0] LT_RED    = 3'b100;

    // A zero duration is treated as one cycle.
    localparam logic [7:0] DUR_VERDE    = (VERDE    == 8'd0) ? 8'd1 : VERDE;
    localparam logic [7:0] DUR_AMARELO  = (AMARELO  == 8'd0) ? 8'd1 : AMARELO;
    localparam logic [7:0] DUR_VERMELHO = (VERMELHO == 8'd0) ? 8'd1 : VERMELHO;

    logic [3:0] phase_q, phase_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] dur;
    logic       last;
    logic       bt_go;

    always_comb begin
        dur = DUR_VERDE;
        case (phase_q)
            P0:      dur = DUR_VERDE;
            P1:      dur = DUR_AMARELO;
            P2:      dur = DUR_VERMELHO;
            P3:      dur = DUR_AMARELO;
            default: dur = 8'd1;
        endcase
        last = (cnt_q == (dur - 8'd1));
    end

`ifdef SEMAFORO_BT_EN
    assign bt_go = bt && (phase_q == P0);
`else
    // Button disabled: port kept, value never reaches the phase logic.
    assign bt_go = bt & 1'b0;
`endif

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q + 8'd1;
        case (phase_q)
            P0: begin
                if (last || bt_go) begin
                    phase_d = P1;
                    cnt_d   = 8'd0;
                end
            end
            P1: begin
                if (last) begin
                    phase_d = P2;
                    cnt_d   = 8'd0;
                end
            end
            P2: begin
                if (last) begin
                    phase_d = P3;
                    cnt_d   = 8'd0;
                end
            end
            P3: begin
                if (last) begin
                    phase_d = P0;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                phase_d = P0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= P0;
            cnt_q   <= 8'd0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs depend on the registered phase only.
    always_comb begin
        A = LT_RED;
        B = LT_RED;
        case (phase_q)
            P0: begin A = LT_GREEN;  B = LT_RED;    end
            P1: begin A = LT_YELLOW; B = LT_RED;    end
            P2: begin A = LT_RED;    B = LT_GREEN;  end
            P3: begin A = LT_RED;    B = LT_YELLOW; end
            default: begin A = LT_RED; B = LT_RED;  end
        endcase
    end

endmodule

// File: tb/tb_semaforo.sv
// Directed, table-driven bench for semaforo: default timing, mid-phase reset, button, zero durations.
module tb_semaforo;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1, bt0 = 1'b0;
    logic rst1 = 1'b1, bt1 = 1'b0;
    logic rst2 = 1'b1, bt2 = 1'b0;
    logic [2:0] a0, b0, a1, b1, a2, b2;

    semaforo u0 (.clk(clk), .rst(rst0), .bt(bt0), .A(a0), .B(b0));
    semaforo #(.VERDE(8'd5), .AMARELO(8'd3), .VERMELHO(8'd2))
        u1 (.clk(clk), .rst(rst1), .bt(bt1), .A(a1), .B(b1));
    semaforo #(.VERDE(8'd0), .AMARELO(8'd1), .VERMELHO(8'd0))
        u2 (.clk(clk), .rst(rst2), .bt(bt2), .A(a2), .B(b2));

    typedef struct {
        logic       rst;
        logic       bt;
        logic [2:0] a;
        logic [2:0] b;
    } vec_t;

    vec_t vecs[24];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int idx, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %b want %b", name, idx, act, exp);
        end
    endtask

    task automatic chk_safe(input string name, input int idx, input logic [2:0] a, input logic [2:0] b);
        checks++;
        if (!($onehot(a) && $onehot(b) && (a == R || b == R))) begin
            errors++;
            $display("FAIL %s[%0d] unsafe lights A=%b B=%b want one-hot with one red", name, idx, a, b);
        end
    endtask

    logic [2:0] u1_a_exp[6];
    logic [2:0] u1_b_exp[6];
    logic [2:0] u2_a_exp[4];
    logic [2:0] u2_b_exp[4];

    initial begin
        // Default timing 1/3/2: period P0 x1, P1 x3, P2 x2, P3 x3; reset hits in P2 at step 14.
        vecs[0]  = '{1'b1, 1'b0, G, R};
        vecs[1]  = '{1'b0, 1'b0, Y, R};
        vecs[2]  = '{1'b0, 1'b0, Y, R};
        vecs[3]  = '{1'b0, 1'b0, Y, R};
        vecs[4]  = '{1'b0, 1'b0, R, G};
        vecs[5]  = '{1'b0, 1'b0, R, G};
        vecs[6]  = '{1'b0, 1'b0, R, Y};
        vecs[7]  = '{1'b0, 1'b0, R, Y};
        vecs[8]  = '{1'b0, 1'b0, R, Y};
        vecs[9]  = '{1'b0, 1'b0, G, R};
        vecs[10] = '{1'b0, 1'b0, Y, R};
        vecs[11] = '{1'b0, 1'b0, Y, R};
        vecs[12] = '{1'b0, 1'b0, Y, R};
        vecs[13] = '{1'b0, 1'b0, R, G};
        vecs[14] = '{1'b1, 1'b0, G, R};
        // bt held high from here: must not alter P1..P3 durations.
        vecs[15] = '{1'b0, 1'b1, Y, R};
        vecs[16] = '{1'b0, 1'b1, Y, R};
        vecs[17] = '{1'b0, 1'b1, Y, R};
        vecs[18] = '{1'b0, 1'b1, R, G};
        vecs[19] = '{1'b0, 1'b1, R, G};
        vecs[20] = '{1'b0, 1'b1, R, Y};
        vecs[21] = '{1'b0, 1'b1, R, Y};
        vecs[22] = '{1'b0, 1'b1, R, Y};
        vecs[23] = '{1'b0, 1'b1, G, R};

`ifdef SEMAFORO_BT_EN
        u1_a_exp = '{G, G, Y, Y, Y, R};
        u1_b_exp = '{R, R, R, R, R, G};
`else
        u1_a_exp = '{G, G, G, G, G, Y};
        u1_b_exp = '{R, R, R, R, R, R};
`endif
        u2_a_exp = '{G, Y, R, R};
        u2_b_exp = '{R, R, G, Y};

        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            rst0 = vecs[i].rst;
            bt0  = vecs[i].bt;
            @(posedge clk);
            @(negedge clk);
            chk("u0_A", i, a0, vecs[i].a);
            chk("u0_B", i, b0, vecs[i].b);
            chk_safe("u0_safe", i, a0, b0);
        end
        rst0 = 1'b0;
        bt0  = 1'b0;

        // VERDE=5: button on the second P0 edge (effective only with the button enabled).
        for (int i = 0; i < 6; i++) begin
            rst1 = (i == 0);
            bt1  = (i == 2);
            @(posedge clk);
            @(negedge clk);
            chk("u1_A", i, a1, u1_a_exp[i]);
            chk("u1_B", i, b1, u1_b_exp[i]);
            chk_safe("u1_safe", i, a1, b1);
        end
        bt1 = 1'b0;

        // Zero durations behave as one: every phase lasts a single cycle.
        for (int i = 0; i < 9; i++) begin
            rst2 = (i == 0);
            @(posedge clk);
            @(negedge clk);
            chk("u2_A", i, a2, u2_a_exp[i % 4]);
            chk("u2_B", i, b2, u2_b_exp[i % 4]);
            chk_safe("u2_safe", i, a2, b2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/semaforo.md
SEMAFORO -- requirements
Module: semaforo

Interface
REQ-001 Parameter VERDE, default 8'd1: A-green phase length in clock cycles, legal 1..255.
REQ-002 Parameter AMARELO, default 8'd3: length in cycles of each yellow phase (A-yellow and B-yellow), legal 1..255.
REQ-003 Parameter VERMELHO, default 8'd2: B-green phase length in cycles (first part of A-red), legal 1..255.
REQ-004 clk  input  1  single clock; all state changes on the rising edge only.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 bt  input  1  request button, sampled on the rising edge; its effect depends on SEMAFORO_BT_EN.
REQ-007 A  output  3  light A, one-hot {red, yellow, green}: green = 3'b001, yellow = 3'b010, red = 3'b100.
REQ-008 B  output  3  light B, same one-hot encoding as A.

Function
REQ-009 Moore FSM with four phases; A and B SHALL be decoded only from the registered phase (no combinational path from bt or rst to outputs).
REQ-010 Phase P0: A=001, B=100, lasts VERDE cycles.
REQ-011 Phase P1: A=010, B=100, lasts AMARELO cycles.
REQ-012 Phase P2: A=100, B=001, lasts VERMELHO cycles.
REQ-013 Phase P3: A=100, B=010, lasts AMARELO cycles.
REQ-014 Phase order SHALL be P0 -> P1 -> P2 -> P3 -> P0, repeating; A is therefore red for VERMELHO+AMARELO cycles.
REQ-015 Timing uses an 8-bit cycle counter cleared on every phase entry; at each rising edge, if counter == duration-1 the phase advances and counter clears, otherwise counter increments.
REQ-016 A phase with duration N SHALL hold its outputs for exactly N rising edges; with duration 1 the phase advances on every edge.
REQ-017 A duration parameter of 0 SHALL behave as 1.
REQ-018 A and B SHALL never both be non-red in the same cycle; exactly one bit of each output is set at all times after reset.
REQ-019 Unused or illegal phase encodings SHALL return to P0 with counter 0 on the next edge.

Reset
REQ-020 On a rising edge with rst=1: phase P0, counter 0, so A=001 and B=100 from that edge on.
REQ-021 rst SHALL override bt and any pending phase transition, and SHALL take effect mid-phase.
REQ-022 P0 timing restarts at the first edge with rst=0 after reset.
REQ-023 Outputs before the first reset edge are undefined.

Configuration
REQ-024 Macro SEMAFORO_BT_EN, when defined, enables the button: bt=1 at a rising edge while in P0 SHALL end P0 at that edge (advance to P1, counter 0), regardless of counter value.
REQ-025 bt=1 in P1, P2 or P3 SHALL be ignored and is not latched.
REQ-026 Without SEMAFORO_BT_EN, bt SHALL be ignored entirely; the port remains present.

Verification (defaults 1/3/2, bt=0 unless stated)
REQ-027 rst=1 for one edge, then free run -> A/B per cycle: 001/100 x1, 010/100 x3, 100/001 x2, 100/010 x3; the 9-cycle period repeats.
REQ-028 rst asserted during P2 -> the next edge gives A=001, B=100, followed by the full sequence from P0.
REQ-029 VERDE=5, SEMAFORO_BT_EN defined, bt=1 on the 2nd P0 edge -> P1 (A=010) from that edge; P0 lasts 2 cycles instead of 5.
REQ-030 Same stimulus without SEMAFORO_BT_EN -> P0 lasts 5 cycles.
REQ-031 bt held high through P1..P3 with SEMAFORO_BT_EN defined -> durations unchanged (3, 2, 3).
REQ-032 All phases checked every cycle -> A and B always one-hot and never both non-red.
